// File: rtl/aes_trace_sequencer_if.sv
// aes_trace_sequencer_if: handshake bundle between the trace sequencer and the AES core
interface aes_trace_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128
);
  logic              core_en;
  logic [DATA_W-1:0] core_data_in;
  logic [KEY_W-1:0]  core_key_in;
  logic [DATA_W-1:0] core_data_out;
  logic              core_valid;
  modport master (output core_en, core_data_in, core_key_in, input core_data_out, core_valid);
  modport slave  (input core_en, core_data_in, core_key_in, output core_data_out, core_valid);
endinterface

// File: rtl/aes_trace_sequencer.sv
// aes_trace_sequencer: N-encryption trace runs (fixed/LFSR/TVLA plaintext), trigger, capture, timeout
// AES_SEQ_KAT_EN adds a fixed-plaintext ciphertext self-check (kat_mismatch, kat_err_cnt)
module aes_trace_sequencer #(
  parameter int DATA_W = 128,
  parameter int KEY_W = 128,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 64,
  parameter int GAP_CYC = 15,
  parameter logic [127:0] LFSR_SEED = 128'h1
) (
  input  logic AES_clk,
  input  logic AES_rst,
  input  logic start,
  input  logic abort,
  input  logic [1:0] mode,
  input  logic [CNT_W-1:0] num_traces,
  input  logic [DATA_W-1:0] fixed_pt,
  input  logic [KEY_W-1:0] key,
  aes_trace_sequencer_if.master core,
  output logic trig,
  output logic busy,
  output logic done,
  output logic [DATA_W-1:0] ct_out,
  output logic ct_valid,
  output logic [CNT_W-1:0] trace_idx,
  output logic timeout_err
`ifdef AES_SEQ_KAT_EN
  ,
  output logic kat_mismatch,
  output logic [CNT_W-1:0] kat_err_cnt
`endif
);
  localparam int TW = $clog2((TIMEOUT > GAP_CYC ? TIMEOUT : GAP_CYC) + 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [127:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [DATA_W-1:0] pt_q, pt_d, din_q, din_d, ct_q, ct_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] n_q, n_d, idx_q, idx_d;
  logic [1:0] mode_q, mode_d;
  logic ctv_q, ctv_d, to_q, to_d, rnd;
`ifdef AES_SEQ_KAT_EN
  logic [DATA_W-1:0] ref_q, ref_d;
  logic have_q, have_d, fix_q, fix_d, mis_q, mis_d;
  logic [CNT_W-1:0] kcnt_q, kcnt_d;
`endif
  always_comb begin
    lfsr_nx = {lfsr_q[126:0], lfsr_q[127] ^ lfsr_q[125] ^ lfsr_q[100] ^ lfsr_q[98]};
    rnd = mode_q == 2'd1 || (mode_q == 2'd2 && idx_q[0]);
    state_d = state_q;
    cnt_d = (state_q == RUN || state_q == GAP) ? cnt_q + 1'b1 : '0;
    lfsr_d = lfsr_q;
    pt_d = pt_q;
    key_d = key_q;
    n_d = n_q;
    mode_d = mode_q;
    din_d = din_q;
    ct_d = ct_q;
    ctv_d = 1'b0;
    idx_d = idx_q;
    to_d = to_q;
`ifdef AES_SEQ_KAT_EN
    ref_d = ref_q;
    have_d = have_q;
    fix_d = fix_q;
    mis_d = mis_q;
    kcnt_d = kcnt_q;
`endif
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = num_traces == '0 ? DONE : LOAD;
          lfsr_d = LFSR_SEED;
          pt_d = fixed_pt;
          key_d = key;
          n_d = num_traces;
          mode_d = mode;
          idx_d = '0;
          to_d = 1'b0;
`ifdef AES_SEQ_KAT_EN
          have_d = 1'b0;
          mis_d = 1'b0;
          kcnt_d = '0;
`endif
        end
        LOAD: begin
          state_d = RUN;
          din_d = rnd ? lfsr_nx[DATA_W-1:0] : pt_q;
          lfsr_d = rnd ? lfsr_nx : lfsr_q;
`ifdef AES_SEQ_KAT_EN
          fix_d = !rnd;
`endif
        end
        RUN: if (core.core_valid || cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = GAP;
          cnt_d = '0;
          ctv_d = core.core_valid;
          to_d = to_q | ~core.core_valid;
          ct_d = core.core_valid ? core.core_data_out : ct_q;
`ifdef AES_SEQ_KAT_EN
          // the first fixed-plaintext result of a run becomes the reference
          if (core.core_valid && fix_q) begin
            have_d = 1'b1;
            ref_d = have_q ? ref_q : core.core_data_out;
            if (have_q && core.core_data_out != ref_q) begin
              mis_d = 1'b1;
              kcnt_d = &kcnt_q ? kcnt_q : kcnt_q + 1'b1;
            end
          end
`endif
        end
        GAP: if (cnt_q == TW'(GAP_CYC - 1)) begin
          idx_d = idx_q + 1'b1;
          state_d = idx_d < n_q ? LOAD : DONE;
          cnt_d = '0;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lfsr_q <= LFSR_SEED;
      pt_q <= '0;
      key_q <= '0;
      n_q <= '0;
      mode_q <= '0;
      din_q <= '0;
      ct_q <= '0;
      ctv_q <= 1'b0;
      idx_q <= '0;
      to_q <= 1'b0;
`ifdef AES_SEQ_KAT_EN
      ref_q <= '0;
      have_q <= 1'b0;
      fix_q <= 1'b0;
      mis_q <= 1'b0;
      kcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lfsr_q <= lfsr_d;
      pt_q <= pt_d;
      key_q <= key_d;
      n_q <= n_d;
      mode_q <= mode_d;
      din_q <= din_d;
      ct_q <= ct_d;
      ctv_q <= ctv_d;
      idx_q <= idx_d;
      to_q <= to_d;
`ifdef AES_SEQ_KAT_EN
      ref_q <= ref_d;
      have_q <= have_d;
      fix_q <= fix_d;
      mis_q <= mis_d;
      kcnt_q <= kcnt_d;
`endif
    end
  end
  // core_en decodes straight from state so reset and abort drop it without a cycle of lag
  assign core.core_en = state_q == RUN;
  assign core.core_data_in = din_q;
  assign core.core_key_in = key_q;
  assign trig = state_q == RUN && cnt_q == '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign ct_out = ct_q;
  assign ct_valid = ctv_q;
  assign trace_idx = idx_q;
  assign timeout_err = to_q;
`ifdef AES_SEQ_KAT_EN
  assign kat_mismatch = mis_q;
  assign kat_err_cnt = kcnt_q;
`endif
endmodule

// File: tb/tb_aes_trace_sequencer.sv
// tb_aes_trace_sequencer: randomized trace runs against a run-timeline model plus directed abort/reset cases
module tb_aes_trace_sequencer;
  localparam int GAP = 15;
  localparam int TMO = 64;
  localparam logic [127:0] SEED = 128'h1;
  logic AES_clk = 1'b0, AES_rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = '0;
  logic [15:0] num_traces = '0;
  logic [127:0] fixed_pt = '0, key = '0;
  logic trig, busy, done, ct_valid, timeout_err;
  logic [127:0] ct_out;
  logic [15:0] trace_idx;
`ifdef AES_SEQ_KAT_EN
  logic kat_mismatch;
  logic [15:0] kat_err_cnt;
`endif
  bit corrupt = 1'b0;
  aes_trace_sequencer_if core_if ();
  aes_trace_sequencer dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst), .start(start), .abort(abort), .mode(mode),
    .num_traces(num_traces), .fixed_pt(fixed_pt), .key(key), .core(core_if.master),
    .trig(trig), .busy(busy), .done(done), .ct_out(ct_out), .ct_valid(ct_valid),
    .trace_idx(trace_idx), .timeout_err(timeout_err)
`ifdef AES_SEQ_KAT_EN
    , .kat_mismatch(kat_mismatch), .kat_err_cnt(kat_err_cnt)
`endif
  );
  always #5 AES_clk = ~AES_clk;
  int cyc = 0;
  always @(posedge AES_clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  function automatic logic [127:0] lfsr_step(input logic [127:0] l);
    return (l << 1) | 128'(l[127] ^ l[125] ^ l[100] ^ l[98]);
  endfunction
  function automatic logic [127:0] fake_aes(input logic [127:0] pt, input logic [127:0] k);
    return {pt[63:0], pt[127:64]} ^ k ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic int pick_lat();
    int r = $urandom_range(0, 9);
    return r < 7 ? int'($urandom_range(1, 20)) : r == 7 ? TMO : r == 8 ? TMO + 1 : int'($urandom_range(1, 3));
  endfunction
  // run timeline model: trigger cycle, RUN length and timeout flag per trace
  int m_n = 0, m_s = 0, m_done = 0, prev_idx = 0;
  bit prev_to = 1'b0, run_valid = 1'b0, chk_on = 1'b0;
  logic [127:0] m_key;
  logic [127:0] pts [16];
  int tt [16], rr [16], lat [16];
  bit tmo [16];
  function automatic int exp_idx(input int c);
    int v = 0;
    if (!run_valid || c < m_s) return prev_idx;
    for (int i = 0; i < m_n; i++) if (tt[i] + rr[i] + GAP <= c) v++;
    return v;
  endfunction
  function automatic bit exp_to(input int c);
    bit v = 1'b0;
    if (!run_valid || c < m_s) return prev_to;
    for (int i = 0; i < m_n; i++) if (tmo[i] && tt[i] + rr[i] <= c) v = 1'b1;
    return v;
  endfunction
  task automatic setup(input int n, input logic [1:0] m, input logic [127:0] fp, input logic [127:0] k);
    logic [127:0] l;
    bit r;
    prev_idx = exp_idx(cyc);
    prev_to = exp_to(cyc);
    m_n = n;
    m_key = k;
    m_s = cyc + 1;
    l = SEED;
    for (int i = 0; i < n; i++) begin
      r = m == 2'd1 || (m == 2'd2 && i % 2 == 1);
      if (r) l = lfsr_step(l);
      pts[i] = r ? l : fp;
      rr[i] = lat[i] > TMO ? TMO : lat[i];
      tmo[i] = lat[i] > TMO;
      tt[i] = i == 0 ? m_s + 1 : tt[i-1] + rr[i-1] + GAP + 1;
    end
    m_done = n == 0 ? m_s : tt[n-1] + rr[n-1] + GAP;
    run_valid = 1'b1;
    num_traces = 16'(n);
    mode = m;
    fixed_pt = fp;
    key = k;
    start = 1'b1;
  endtask
  task automatic do_run(input int n, input logic [1:0] m, input logic [127:0] fp, input logic [127:0] k);
    int sp;
    @(negedge AES_clk);
    #1 setup(n, m, fp, k);
    @(negedge AES_clk);
    #1 start = 1'b0;
    fixed_pt = rand128();
    key = rand128();
    if (m_done > cyc) begin
      sp = $urandom_range(0, m_done - cyc - 1);
      repeat (sp) @(negedge AES_clk);
      #1 start = 1'b1;
      @(negedge AES_clk);
      #1 start = 1'b0;
    end
    while (cyc < m_done + 2) @(negedge AES_clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 0);
    chk({tag, "_trig"}, 128'(trig), 0);
    chk({tag, "_core_en"}, 128'(core_if.core_en), 0);
    chk({tag, "_done"}, 128'(done), 0);
    chk({tag, "_ct_valid"}, 128'(ct_valid), 0);
    chk({tag, "_ct_out"}, ct_out, 0);
    chk({tag, "_trace_idx"}, 128'(trace_idx), 0);
    chk({tag, "_timeout_err"}, 128'(timeout_err), 0);
    chk({tag, "_core_data_in"}, core_if.core_data_in, 0);
    chk({tag, "_core_key_in"}, core_if.core_key_in, 0);
  endtask
  // AES core stand-in: valid on the lat-th cycle of core_en, junk valids while idle
  int k_run = 0;
  always @(negedge AES_clk) begin
    if (core_if.core_en) begin
      k_run++;
      core_if.core_valid = k_run == lat[trace_idx[3:0]];
      core_if.core_data_out = fake_aes(core_if.core_data_in, core_if.core_key_in) ^
                              ((corrupt && trace_idx == 16'd2) ? 128'hff : 128'h0);
    end else begin
      k_run = 0;
      core_if.core_valid = $urandom_range(0, 3) == 0;
      core_if.core_data_out = rand128();
    end
  end
  bit e_busy, e_trig, e_en, e_ctv, e_done;
  int ei, ci;
  always @(negedge AES_clk) if (chk_on) begin
    e_trig = 1'b0;
    e_en = 1'b0;
    e_ctv = 1'b0;
    ei = 0;
    ci = 0;
    e_busy = run_valid && cyc >= m_s && cyc <= m_done;
    e_done = run_valid && cyc == m_done;
    if (run_valid && cyc >= m_s) for (int i = 0; i < m_n; i++) begin
      if (cyc == tt[i]) e_trig = 1'b1;
      if (cyc >= tt[i] && cyc < tt[i] + rr[i]) begin e_en = 1'b1; ei = i; end
      if (!tmo[i] && cyc == tt[i] + rr[i]) begin e_ctv = 1'b1; ci = i; end
    end
    chk("busy", 128'(busy), 128'(e_busy));
    chk("trig", 128'(trig), 128'(e_trig));
    chk("core_en", 128'(core_if.core_en), 128'(e_en));
    chk("ct_valid", 128'(ct_valid), 128'(e_ctv));
    chk("done", 128'(done), 128'(e_done));
    chk("trace_idx", 128'(trace_idx), 128'(exp_idx(cyc)));
    chk("timeout_err", 128'(timeout_err), 128'(exp_to(cyc)));
    if (e_en) begin
      chk("core_data_in", core_if.core_data_in, pts[ei]);
      chk("core_key_in", core_if.core_key_in, m_key);
    end
    if (e_ctv) chk("ct_out", ct_out, fake_aes(pts[ci], m_key));
  end
  initial begin
    int w;
    bit seen;
    logic [127:0] fp;
    repeat (3) @(negedge AES_clk);
    chk_zero("reset");
    chk("lfsr_pin_seed", lfsr_step(128'h1), 128'h2);
    chk("lfsr_pin_msb", lfsr_step(128'h1 << 127), 128'h1);
    chk("lfsr_pin_tap126", lfsr_step(128'h1 << 125), (128'h1 << 126) | 128'h1);
    #1 AES_rst = 1'b0;
    chk_on = 1'b1;
    foreach (lat[i]) lat[i] = 7;
    do_run(3, 2'd0, 128'h00000099_00000000_00000000_00000000, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    chk("pin_fixed_pt", pts[2], 128'h00000099_00000000_00000000_00000000);
    chk("pin_start_to_trig", 128'(tt[0] - m_s + 1), 128'd2);
    chk("pin_trace_spacing", 128'(tt[1] - tt[0]), 128'd23);
    foreach (lat[i]) lat[i] = pick_lat();
    do_run(4, 2'd1, rand128(), 128'h1234);
    do_run(4, 2'd1, rand128(), 128'h1234);
    chk("pin_rand_first", pts[0], 128'h2);
    chk("pin_rand_second", pts[1], 128'h4);
    fp = rand128();
    do_run(4, 2'd2, fp, rand128());
    chk("pin_tvla_fixed0", pts[0], fp);
    chk("pin_tvla_rand1", pts[1], 128'h2);
    chk("pin_tvla_fixed2", pts[2], fp);
    chk("pin_tvla_rand3", pts[3], 128'h4);
    foreach (lat[i]) lat[i] = 99;
    do_run(2, 2'd0, rand128(), rand128());
    chk("hang_timeout_err", 128'(timeout_err), 128'd1);
    chk("hang_trace_idx", 128'(trace_idx), 128'd2);
    do_run(0, 2'd1, rand128(), rand128());
    for (int r = 0; r < 10; r++) begin
      foreach (lat[i]) lat[i] = pick_lat();
      do_run($urandom_range(0, 6), 2'($urandom_range(0, 3)), rand128(), rand128());
    end
    chk_on = 1'b0;
    foreach (lat[i]) lat[i] = 30;
    @(negedge AES_clk);
    #1 num_traces = 16'd3;
    mode = 2'd1;
    start = 1'b1;
    @(negedge AES_clk);
    #1 start = 1'b0;
    w = 0;
    while (!(trace_idx == 16'd1 && core_if.core_en) && w < 500) begin @(negedge AES_clk); w++; end
    chk("abort_reach_run1", 128'(w < 500), 128'd1);
    #1 abort = 1'b1;
    @(negedge AES_clk);
    chk("abort_core_en", 128'(core_if.core_en), 0);
    chk("abort_busy", 128'(busy), 0);
    chk("abort_done", 128'(done), 0);
    #1 abort = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge AES_clk); if (done || busy) seen = 1'b1; end
    chk("abort_no_done", 128'(seen), 0);
`ifdef AES_SEQ_KAT_EN
    foreach (lat[i]) lat[i] = 5;
    corrupt = 1'b1;
    #1 num_traces = 16'd4;
    mode = 2'd0;
    start = 1'b1;
    @(negedge AES_clk);
    #1 start = 1'b0;
    w = 0;
    while (!done && w < 1000) begin @(negedge AES_clk); w++; end
    chk("kat_run_done", 128'(w < 1000), 128'd1);
    chk("kat_mismatch", 128'(kat_mismatch), 128'd1);
    chk("kat_err_cnt", 128'(kat_err_cnt), 128'd1);
    corrupt = 1'b0;
`endif
    foreach (lat[i]) lat[i] = 10;
    @(negedge AES_clk);
    #1 num_traces = 16'd2;
    mode = 2'd2;
    start = 1'b1;
    @(negedge AES_clk);
    #1 start = 1'b0;
    w = 0;
    while (!ct_valid && w < 300) begin @(negedge AES_clk); w++; end
    chk("gap_reached", 128'(w < 300), 128'd1);
    @(negedge AES_clk);
    #2 AES_rst = 1'b1;
    #1 chk_zero("mid_gap_reset");
    repeat (2) @(negedge AES_clk);
    #1 AES_rst = 1'b0;
    run_valid = 1'b0;
    prev_idx = 0;
    prev_to = 1'b0;
    chk_on = 1'b1;
    for (int r = 0; r < 3; r++) begin
      foreach (lat[i]) lat[i] = pick_lat();
      do_run($urandom_range(1, 5), 2'($urandom_range(0, 3)), rand128(), rand128());
    end
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
